// File: rtl/booth_r4_mult_param.sv
// Radix-4 Booth sequential multiplier.
// Operands are extended to WIDTH+2 bits so one datapath covers both signed
// and unsigned inputs. Each CALC cycle retires two multiplier bits, so a
// result takes WIDTH/2+1 cycles.
module booth_r4_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EW = WIDTH + 2;          // extended operand width
  localparam int AW = WIDTH + 3;          // accumulator width (room for +/-2M)
  localparam int NITER = WIDTH / 2 + 1;   // digits in an EW-bit multiplier
  localparam int CW = $clog2(NITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     acc_reg;
  logic [EW-1:0]     q_reg;
  logic              qm1_reg;
  logic [EW-1:0]     m_reg;
  logic [CW-1:0]     cnt_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic              accept;
  logic              last_step;

  logic [AW-1:0]     m_ext;
  logic [AW-1:0]     m_dbl;
  logic [AW-1:0]     addend;
  logic [AW-1:0]     addend_inv;
  logic              negate;
  logic [AW-1:0]     sum;
  logic [AW-1:0]     acc_next;
  logic [EW-1:0]     q_next;
  logic              qm1_next;
  logic [2*WIDTH-1:0] result;
  logic [EW-1:0]     m_load;
  logic [EW-1:0]     q_load;

  // State register; reset aborts any multiplication in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus the handshake outputs decoded from state.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt_reg == CW'(1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Booth digit recode, add/subtract and the 2-bit arithmetic right shift.
  always_comb begin
    m_ext  = {m_reg[EW-1], m_reg};
    m_dbl  = {m_reg, 1'b0};
    addend = '0;
    negate = 1'b0;
    case ({q_reg[1:0], qm1_reg})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_dbl;
      3'b100: begin
        addend = m_dbl;
        negate = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = m_ext;
        negate = 1'b1;
      end
      default: addend = '0;
    endcase
    // Subtraction reuses the adder: invert the operand, carry in a one.
    addend_inv = negate ? ~addend : addend;
    sum        = acc_reg + addend_inv + {{(AW-1){1'b0}}, negate};
    acc_next   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_next     = {sum[1:0], q_reg[EW-1:2]};
    qm1_next   = q_reg[1];
    // After the final shift the full product sits in {acc, q}; keep the low half.
    result     = {acc_next[WIDTH-3:0], q_next};
    m_load     = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                             : {2'b00, multiplicand};
    q_load     = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                             : {2'b00, multiplier};
  end

  // Operand capture on accept, iteration in CALC, result load on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      m_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (accept) begin
      m_reg   <= m_load;
      q_reg   <= q_load;
      acc_reg <= '0;
      qm1_reg <= 1'b0;
      cnt_reg <= CW'(NITER);
    end else if (state_reg == CALC) begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
      qm1_reg <= qm1_next;
      cnt_reg <= cnt_reg - CW'(1);
      if (last_step) begin
        product_reg <= result;
      end
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_booth_r4_mult_param.sv
// Directed bench for the radix-4 Booth multiplier: a WIDTH=8 instance for
// latency, corner operands, ignored starts and mid-operation reset, and a
// WIDTH=16 instance driven back-to-back against a reference product.
module tb_booth_r4_mult_param;

  logic        clk;
  logic        rst_n;

  logic        start8, sm8;
  logic [7:0]  m8, q8;
  logic        ready8, done8;
  logic [15:0] product8;

  logic        start16, sm16;
  logic [15:0] m16, q16;
  logic        ready16, done16;
  logic [31:0] product16;

  int n_vec;
  int n_err;
  int done_cnt8;
  int cyc;

  localparam int NV16 = 11;
  logic        sm_t[NV16];
  logic [15:0] m_t[NV16];
  logic [15:0] q_t[NV16];
  logic [31:0] exp_t[NV16];
  int          d16;
  int          last_done16;

  booth_r4_mult_param #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start8),
    .signed_mode  (sm8),
    .multiplicand (m8),
    .multiplier   (q8),
    .ready        (ready8),
    .done         (done8),
    .product      (product8)
  );

  booth_r4_mult_param #(.WIDTH(16)) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start16),
    .signed_mode  (sm16),
    .multiplicand (m16),
    .multiplier   (q16),
    .ready        (ready16),
    .done         (done16),
    .product      (product16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a, input logic [15:0] b);
    longint p;
    if (sm) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'({48'd0, a}) * longint'({48'd0, b});
    return p[31:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && done8) done_cnt8++;
  end

  // WIDTH=16 result monitor: product order and spacing between done pulses.
  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (d16 < NV16) begin
        check($sformatf("w16_prod%0d", d16), {32'd0, product16}, {32'd0, exp_t[d16]});
        $display("txn w16 #%0d sm=%0b m=%h q=%h product=%h", d16, sm_t[d16], m_t[d16], q_t[d16], product16);
      end
      if (d16 > 0) check($sformatf("w16_gap%0d", d16), 64'(cyc - last_done16), 64'd11);
      last_done16 = cyc;
      d16++;
    end
  end

  // One WIDTH=8 multiplication; caller sits #1 after a rising edge in IDLE.
  task automatic run8(input string tag, input logic sm, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] exp, input bit poke_calc);
    int   lat;
    int   d0;
    bit   rdy_low;
    logic [15:0] prev;
    check({tag, "_rdy"}, {63'd0, ready8}, 64'd1);
    d0   = done_cnt8;
    prev = product8;
    sm8 = sm; m8 = m; q8 = q; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; sm8 = ~sm; m8 = ~m; q8 = 8'h5A;
    lat = 0; rdy_low = 1'b1;
    while (!done8 && lat < 20) begin
      if (ready8) rdy_low = 1'b0;
      if (lat > 0) check({tag, "_hold"}, {48'd0, product8}, {48'd0, prev});
      if (poke_calc && lat == 2) begin
        start8 = 1'b1; sm8 = 1'b0; m8 = 8'h11; q8 = 8'h22;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_prod"}, {48'd0, product8}, {48'd0, exp});
    check({tag, "_rdy_busy"}, {63'd0, rdy_low}, 64'd1);
    check({tag, "_rdy_done"}, {63'd0, ready8}, 64'd0);
    $display("txn w8 %s sm=%0b m=%h q=%h product=%h latency=%0d", tag, sm, m, q, product8, lat);
    // start during DONE must not be taken
    start8 = 1'b1; m8 = 8'h33; q8 = 8'h44;
    @(posedge clk); #1;
    start8 = 1'b0;
    check({tag, "_done_fall"}, {63'd0, done8}, 64'd0);
    check({tag, "_idle"}, {63'd0, ready8}, 64'd1);
    @(posedge clk); #1;
    check({tag, "_not_taken"}, {63'd0, ready8}, 64'd1);
    check({tag, "_prod_kept"}, {48'd0, product8}, {48'd0, exp});
    check({tag, "_one_done"}, 64'(done_cnt8 - d0), 64'd1);
  endtask

  initial begin
    int t;
    int d0;
    n_vec = 0; n_err = 0; done_cnt8 = 0; cyc = 0; d16 = 0; last_done16 = 0;
    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
    start16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready8", {63'd0, ready8}, 64'd1);
    check("rst_done8", {63'd0, done8}, 64'd0);
    check("rst_prod8", {48'd0, product8}, 64'd0);
    check("rst_prod16", {32'd0, product16}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8("s_min_sq",  1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
    run8("u_max_sq",  1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    run8("s_m1_sq",   1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
    run8("s_m1_x127", 1'b1, 8'hFF, 8'h7F, 16'hFF81, 1'b0);
    run8("s_zero",    1'b1, 8'h00, 8'h80, 16'h0000, 1'b0);
    run8("u_12x10",   1'b0, 8'h0C, 8'h0A, 16'h0078, 1'b0);
    run8("s_127sq",   1'b1, 8'h7F, 8'h7F, 16'h3F01, 1'b0);
    run8("s_5xm3",    1'b1, 8'h05, 8'hFD, 16'hFFF1, 1'b0);
    run8("poke_calc", 1'b1, 8'h06, 8'h07, 16'h002A, 1'b1);

    // Reset in the third CALC cycle: immediate clear, no done afterwards.
    d0 = done_cnt8;
    sm8 = 1'b0; m8 = 8'h07; q8 = 8'h09; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_prod", {48'd0, product8}, 64'd0);
    check("arst_ready", {63'd0, ready8}, 64'd1);
    check("arst_done", {63'd0, done8}, 64'd0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("arst_no_done", 64'(done_cnt8 - d0), 64'd0);
    check("arst_prod_hold", {48'd0, product8}, 64'd0);
    run8("u_3x5", 1'b0, 8'h03, 8'h05, 16'h000F, 1'b0);

    // WIDTH=16: corner table plus random operands, start held high throughout.
    sm_t[0] = 1'b1; m_t[0] = 16'h8000; q_t[0] = 16'h8000; exp_t[0] = 32'h4000_0000;
    sm_t[1] = 1'b0; m_t[1] = 16'hFFFF; q_t[1] = 16'hFFFF; exp_t[1] = 32'hFFFE_0001;
    sm_t[2] = 1'b1; m_t[2] = 16'hFFFF; q_t[2] = 16'hFFFF; exp_t[2] = 32'h0000_0001;
    sm_t[3] = 1'b1; m_t[3] = 16'h7FFF; q_t[3] = 16'h8000; exp_t[3] = 32'hC000_8000;
    sm_t[4] = 1'b1; m_t[4] = 16'h0003; q_t[4] = 16'hFFFB; exp_t[4] = 32'hFFFF_FFF1;
    sm_t[5] = 1'b0; m_t[5] = 16'h1234; q_t[5] = 16'h0010; exp_t[5] = 32'h0001_2340;
    sm_t[6] = 1'b0; m_t[6] = 16'h0000; q_t[6] = 16'hABCD; exp_t[6] = 32'h0000_0000;
    for (int i = 7; i < NV16; i++) begin
      sm_t[i] = 1'($urandom_range(0, 1));
      m_t[i]  = 16'($urandom);
      q_t[i]  = 16'($urandom);
      exp_t[i] = ref16(sm_t[i], m_t[i], q_t[i]);
    end
    for (int i = 0; i < NV16; i++) begin
      t = 0;
      while (!ready16 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) check("w16_ready_timeout", 64'(t), 64'd0);
      sm16 = sm_t[i]; m16 = m_t[i]; q16 = q_t[i]; start16 = 1'b1;
      @(posedge clk); #1;
    end
    start16 = 1'b0;
    t = 0;
    while (d16 < NV16 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("w16_done_count", 64'(d16), 64'(NV16));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
